// File: rtl/pixel_packer.sv
// pixel_packer: packs NUM_BYTES consecutive BYTE_W-bit input bytes into one
// NUM_BYTES*BYTE_W-bit output word behind a valid/ready handshake on both sides.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_data valid this cycle
//   in_ready   - block accepts in_data this cycle
//   in_data    - byte to pack (BYTE_W bits)
//   in_sof     - accepted byte starts a new word; any partial word is dropped
//   out_valid  - out_data holds a complete word
//   out_ready  - downstream consumes out_data this cycle
//   out_data   - packed word (NUM_BYTES*BYTE_W bits)
//   resync     - one-cycle pulse when in_sof discarded a partial word
//
// Build option:
//   PACKER_LSB_FIRST_EN - first byte of a word lands in the LSBs of out_data.
//                         Undefined (default): first byte lands in the MSBs.
//
// Legal NUM_BYTES range is 2..8; anything else stops elaboration.

module pixel_packer #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W-1:0]           in_data,
    input  logic                        in_sof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_BYTES*BYTE_W-1:0] out_data,
    output logic                        resync
);

    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WORD_W = NUM_BYTES * BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    generate
        if (NUM_BYTES < 2 || NUM_BYTES > 8) begin : g_bad_cfg
            $error("pixel_packer: NUM_BYTES must be in 2..8");
        end
    endgenerate

    logic [IDX_W-1:0]                    idx;
    logic [NUM_BYTES-2:0][BYTE_W-1:0]    stage;
    logic [WORD_W-1:0]                   word_next;
    logic                                accept_in;
    logic                                accept_out;
    logic                                load_word;

    // Single output holding register: a consumed word frees the slot on the
    // same edge, so a new word can follow without a bubble.
    assign in_ready   = !out_valid || out_ready;
    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;
    assign load_word  = accept_in && !in_sof && (idx == LAST_IDX);

    // Word assembled from the staged bytes plus the byte arriving now.
    always_comb begin
        word_next = '0;
        for (int k = 0; k < NUM_BYTES - 1; k++) begin
`ifdef PACKER_LSB_FIRST_EN
            word_next[k*BYTE_W +: BYTE_W] = stage[k];
`else
            word_next[(NUM_BYTES-1-k)*BYTE_W +: BYTE_W] = stage[k];
`endif
        end
`ifdef PACKER_LSB_FIRST_EN
        word_next[(NUM_BYTES-1)*BYTE_W +: BYTE_W] = in_data;
`else
        word_next[0 +: BYTE_W] = in_data;
`endif
    end

    // Byte index and staging slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            stage <= '0;
        end else if (accept_in) begin
            if (in_sof) begin
                // Resynchronise: this byte is slot 0 of a fresh word.
                stage[0] <= in_data;
                idx      <= IDX_W'(1);
            end else if (idx == LAST_IDX) begin
                idx <= '0;
            end else begin
                // Slot-by-slot compare keeps the index width independent of
                // the staging array size.
                for (int k = 0; k < NUM_BYTES - 1; k++) begin
                    if (idx == IDX_W'(k)) begin
                        stage[k] <= in_data;
                    end
                end
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_word) begin
            out_valid <= 1'b1;
            out_data  <= word_next;
        end else if (accept_out) begin
            out_valid <= 1'b0;
        end
    end

    // Pulse only when a partial word was actually thrown away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resync <= 1'b0;
        end else begin
            resync <= accept_in && in_sof && (idx != '0);
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Testbench for pixel_packer (default parameters). Honours PACKER_LSB_FIRST_EN
// when it is defined for the build.

module tb_pixel_packer;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 3;
    localparam int WORD_W    = BYTE_W * NUM_BYTES;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              in_sof;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              resync;

    pixel_packer #(.BYTE_W(BYTE_W), .NUM_BYTES(NUM_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .resync    (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    logic [BYTE_W-1:0] mb [NUM_BYTES];
    int                mcnt;
    logic              mv;
    logic              mr;
    logic [WORD_W-1:0] m_word;
    logic [WORD_W-1:0] sb [$];
    wire               m_acc = in_valid && (!mv || out_ready);

    always_comb begin
        m_word = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            logic [BYTE_W-1:0] b;
            b = (k == NUM_BYTES - 1) ? in_data : mb[k];
`ifdef PACKER_LSB_FIRST_EN
            m_word[k*BYTE_W +: BYTE_W] = b;
`else
            m_word[(NUM_BYTES-1-k)*BYTE_W +: BYTE_W] = b;
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0;
            mv   <= 1'b0;
            mr   <= 1'b0;
            sb.delete();
        end else begin
            mr <= m_acc && in_sof && (mcnt != 0);
            if (m_acc && !in_sof && mcnt == NUM_BYTES - 1) begin
                sb.push_back(m_word);
                mv   <= 1'b1;
                mcnt <= 0;
            end else begin
                if (mv && out_ready) mv <= 1'b0;
                if (m_acc) begin
                    if (in_sof) begin
                        mb[0] <= in_data;
                        mcnt  <= 1;
                    end else begin
                        mb[mcnt] <= in_data;
                        mcnt     <= mcnt + 1;
                    end
                end
            end
        end
    end

    // Monitor: every falling edge, compare outputs against the model
    int                rs_cnt   = 0;
    int                word_cnt = 0;
    int                low_cnt  = 0;
    bit                b2b      = 1'b0;
    logic [WORD_W-1:0] last_word = '0;

    always @(negedge clk) begin
        chk("valid", out_valid, mv);
        chk("in_ready", in_ready, !mv || out_ready);
        chk("resync", resync, mr);
        if (!rst_n) chk("rst_data", out_data, 0);
        if (resync) rs_cnt++;
        if (b2b && !in_ready) low_cnt++;
        if (mv) begin
            if (sb.size() == 0) begin
                chk("sb_empty", sb.size(), 1);
            end else begin
                chk("data", out_data, sb[0]);
                if (out_ready) begin
                    last_word = sb.pop_front();
                    word_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [BYTE_W-1:0] d, input logic sof);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    logic [WORD_W-1:0] exp_first;
    int w0;
    int r0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out_data, 0);
        chk("rst_resync", resync, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // Basic word
`ifdef PACKER_LSB_FIRST_EN
        exp_first = 24'h563412;
`else
        exp_first = 24'h123456;
`endif
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        idle(1);
        chk("latency_valid", out_valid, 0);
        chk("basic_word", last_word, exp_first);
        idle(2);
        chk("basic_drain", sb.size(), 0);

        // Back-to-back, no bubbles
        w0  = word_cnt;
        b2b = 1'b1;
        for (int i = 1; i <= 6; i++) send(BYTE_W'(i), 1'b0);
        b2b = 1'b0;
        idle(3);
        chk("b2b_rdy_low", low_cnt, 0);
        chk("b2b_words", word_cnt - w0, 2);
`ifdef PACKER_LSB_FIRST_EN
        chk("b2b_last", last_word, 24'h060504);
`else
        chk("b2b_last", last_word, 24'h040506);
`endif

        // Backpressure
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        fork
            begin
                send(8'h04, 1'b0);
                send(8'h05, 1'b0);
                send(8'h06, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_ready", in_ready, 0);
`ifdef PACKER_LSB_FIRST_EN
                chk("bp_hold", out_data, 24'h030201);
`else
                chk("bp_hold", out_data, 24'h010203);
`endif
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);
        chk("bp_drain", sb.size(), 0);

        // Resynchronisation
        r0 = rs_cnt;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        idle(3);
        chk("resync_pulses", rs_cnt - r0, 1);
`ifdef PACKER_LSB_FIRST_EN
        chk("resync_word", last_word, 24'hEEDDCC);
`else
        chk("resync_word", last_word, 24'hCCDDEE);
`endif

        // Reset mid-word
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        idle(0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_out", out_data, 0);
        chk("mrst_resync", resync, 0);
        chk("mrst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        send(8'h09, 1'b0);
        idle(3);
`ifdef PACKER_LSB_FIRST_EN
        chk("post_rst_word", last_word, 24'h090807);
`else
        chk("post_rst_word", last_word, 24'h070809);
`endif
        chk("final_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
